// File: rtl/score_digits.sv
// score_digits: sequential binary-to-decimal character converter.
// Runs one double-dabble shift per clock, then blanks leading zeros (code 4'ha).
// If the value does not fit in N digits, every position is blanked and the
// overflow flag is set.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   start    request a conversion; sampled only while idle
//   value    unsigned binary input, captured on the accepting edge
//   busy     high while a conversion is in progress
//   done     one-cycle pulse; chars/overflow are updated in the same cycle
//   chars    N 4-bit character codes; the leftmost position is in the top nibble
//   overflow last converted value was >= 10^N
module score_digits #(
  parameter int unsigned W = 14,
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   value,
  output logic           busy,
  output logic           done,
  output logic [4*N-1:0] chars,
  output logic           overflow
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t         state, state_nx;
  logic [W-1:0]   bin;
  logic [4*N-1:0] bcd;
  logic [4*N-1:0] bcd_adj;
  logic [4*N-1:0] chars_nx;
  logic           carry;
  logic [CW-1:0]  cnt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Add-3 correction: each 4-bit digit is adjusted on its own, with no carry
  // between digits
  always_comb begin
    bcd_adj = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      else                       bcd_adj[4*i +: 4] = bcd[4*i +: 4];
    end
  end

  // Leading-zero blanking, scanned from the leftmost digit. The units digit is
  // always shown. On overflow, every position is blank.
  always_comb begin
    logic seen;
    int unsigned idx;
    seen     = 1'b0;
    idx      = 0;
    chars_nx = {N{4'ha}};
    if (!carry) begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = N - 1 - k;
        if (!seen && bcd[4*idx +: 4] == 4'd0 && idx != 0) begin
          chars_nx[4*idx +: 4] = 4'ha;
        end else begin
          chars_nx[4*idx +: 4] = bcd[4*idx +: 4];
          seen = 1'b1;
        end
      end
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      bin      <= '0;
      bcd      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      chars    <= {N{4'ha}};
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin   <= value;
            bcd   <= '0;
            carry <= 1'b0;
            cnt   <= CW'(W);
          end
        end
        SHIFT: begin
          // Shift {carry, bcd, bin} left by one bit. The bit that leaves the
          // top digit is ORed into the sticky carry.
          carry <= carry | bcd_adj[4*N-1];
          bcd   <= {bcd_adj[4*N-2:0], bin[W-1]};
          bin   <= {bin[W-2:0], 1'b0};
          cnt   <= cnt - CW'(1);
        end
        FINISH: begin
          chars    <= chars_nx;
          overflow <= carry;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_score_digits.sv
// Self-checking bench for score_digits, with W=14 and N=4.
// Expected values come from a decimal model that uses division and modulo.
module tb_score_digits;

  localparam int unsigned W = 14;
  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   value;
  logic           busy;
  logic           done;
  logic [4*N-1:0] chars;
  logic           overflow;

  int total = 0;
  int bad   = 0;

  score_digits #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy), .done(done), .chars(chars), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model. Bit N*4 is the overflow flag; the low bits are the chars.
  function automatic logic [4*N:0] model(input int v);
    logic [4*N:0] r;
    int p;
    int d;
    bit seen;
    p = 1;
    for (int i = 0; i < N; i++) p = p * 10;
    r = '0;
    if (v >= p) begin
      for (int i = 0; i < N; i++) r[4*i +: 4] = 4'ha;
      r[4*N] = 1'b1;
      return r;
    end
    seen = 0;
    for (int i = N - 1; i >= 0; i--) begin
      p = p / 10;
      d = (v / p) % 10;
      if (d != 0 || i == 0) seen = 1;
      r[4*i +: 4] = seen ? d[3:0] : 4'ha;
    end
    return r;
  endfunction

  function automatic logic [15:0] pack(input int a, input int b, input int c, input int d);
    pack = {a[3:0], b[3:0], c[3:0], d[3:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge in an idle cycle. start is raised here, that cycle
  // is cycle 0, and the task returns #1 into cycle 1.
  task automatic kick(input int v);
    start = 1'b1;
    value = v[W-1:0];
    tick();
    start = 1'b0;
    value = W'($urandom);
  endtask

  // Runs from cycle c0 up to cycle W+2 and expects done exactly there.
  task automatic wait_done(input int c0, input logic [15:0] exp_chars,
                           input logic exp_ovf, input bit full, input string tag);
    for (int c = c0; c < W + 2; c++) begin
      if (full) begin
        check({tag, ".busy"}, 32'(busy), 32'd1);
        check({tag, ".nodone"}, 32'(done), 32'd0);
      end else if (done) begin
        check({tag, ".early"}, 32'(done), 32'd0);
      end
      tick();
    end
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".busy0"}, 32'(busy), 32'd0);
    check({tag, ".chars"}, 32'(chars), 32'(exp_chars));
    check({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic conv(input int v, input logic [15:0] exp_chars, input logic exp_ovf, input string tag);
    kick(v);
    wait_done(1, exp_chars, exp_ovf, 1'b1, tag);
  endtask

  initial begin
    logic [4*N:0] m;
    int v;
    rst = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (3) tick();
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(done), 0);
    check("rst.ovf", 32'(overflow), 0);
    check("rst.chars", 32'(chars), 32'h aaaa);
    rst = 1'b0;
    tick();

    conv(0, pack(10, 10, 10, 0), 1'b0, "zero");
    conv(2048, pack(2, 0, 4, 8), 1'b0, "v2048");
    conv(7, pack(10, 10, 10, 7), 1'b0, "v7");
    conv(100, pack(10, 1, 0, 0), 1'b0, "v100");
    conv(9999, pack(9, 9, 9, 9), 1'b0, "v9999");
    conv(10000, pack(10, 10, 10, 10), 1'b1, "v10000");
    conv(16383, pack(10, 10, 10, 10), 1'b1, "v16383");

    // A start while busy is ignored; a start in the done cycle is accepted
    kick(512);
    repeat (4) tick();
    start = 1'b1;
    value = 14'd64;
    tick();
    start = 1'b0;
    wait_done(6, pack(10, 5, 1, 2), 1'b0, 1'b1, "ign512");
    kick(64);
    wait_done(1, pack(10, 10, 6, 4), 1'b0, 1'b1, "b2b64");

    // Outputs hold while idle
    repeat (5) tick();
    check("hold.chars", 32'(chars), 32'(pack(10, 10, 6, 4)));
    check("hold.done", 32'(done), 0);

    // Reset in the middle of a conversion
    conv(1024, pack(1, 0, 2, 4), 1'b0, "v1024");
    kick(8);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst.chars", 32'(chars), 32'h aaaa);
    check("mrst.busy", 32'(busy), 0);
    check("mrst.ovf", 32'(overflow), 0);
    begin
      int seen_done = 0;
      for (int i = 0; i < 20; i++) begin
        if (done || busy) seen_done++;
        tick();
      end
      check("mrst.nodone", 32'(seen_done), 0);
    end
    conv(8, pack(10, 10, 10, 8), 1'b0, "v8");

    // Reset also clears a set overflow flag
    conv(12345, pack(10, 10, 10, 10), 1'b1, "v12345");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2.ovf", 32'(overflow), 0);
    tick();

    for (int n = 0; n < 2000; n++) begin
      v = int'($urandom_range(16383, 0));
      m = model(v);
      kick(v);
      wait_done(1, m[15:0], m[16], 1'b0, "rand");
      if ($urandom_range(1, 0) == 1) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/score_digits.md
# score_digits

Sequential binary-to-character converter that turns an unsigned binary value into N decimal character codes for the text renderer, using one double-dabble shift per clock. It produces the same 4-bit character encoding the tile renderer consumes (0–9 = digits, 4'ha = blank), with leading-zero suppression. It sits between game logic and the text/tile rendering path, and feeds score and move-counter displays whose values are not restricted to powers of two.

## Interface

Parameters:
- W, 14, width of the binary input value.
- N, 4, number of decimal character positions produced.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a conversion of `value`; sampled only in IDLE.
- value  input  W  unsigned binary value; captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; `chars` and `overflow` are updated in the same cycle.
- chars  output  4N  character codes; bits [4N-1:4N-4] are the leftmost (most significant) position, and bits [3:0] are the units position.
- overflow  output  1  set when the last converted value was ≥ 10^N.

## Operation

- States: IDLE, SHIFT, FINISH.
- **IDLE:**
  - When start=1, latch `value` into the shift register, clear the 4N-bit BCD accumulator and the sticky carry bit, load the iteration counter with W, and go to SHIFT.
  - When start=0, stay in IDLE.
- **SHIFT, one iteration per cycle:**
  - Add 3 to every BCD digit that is ≥ 5.
  - Shift {carry, BCD, bin} left by 1. The bit leaving the top of the BCD accumulator ORs into the sticky carry.
  - Decrement the counter. After the W-th shift, go to FINISH.
- **FINISH:**
  - Register the result into `chars`, set `overflow` to the sticky carry value, pulse `done`, and go to IDLE.
- Leading-zero suppression:
  - Scan digits from the left. Every zero digit before the first nonzero digit becomes 4'ha.
  - The units position is never blanked, so value 0 gives blanks followed by "0".
  - Zeros after the first nonzero digit are kept.
- Overflow: when the sticky carry is 1, `chars` becomes all 4'ha and `overflow` = 1. Otherwise `overflow` = 0.
- `start` is ignored in SHIFT and FINISH. It is not queued.
- `chars` and `overflow` hold their values between `done` pulses. `value` may change freely after the accepting edge.
- Arithmetic:
  - The add-3 correction is per digit and 4 bits wide, with no carry between digits.
  - The iteration counter is at least clog2(W+1) bits.

## Timing

- Reset values:
  - busy = 0, done = 0, overflow = 0.
  - chars = {N{4'ha}}.
  - State = IDLE, with the counter and accumulators cleared.
- Cycle numbering: start is high in cycle 0 while the block is in IDLE.
  - `busy` is high in cycles 1..W+1.
  - `done` = 1 in cycle W+2, with the new `chars`/`overflow` valid and `busy` = 0.
  - Latency from start to done is W+2 cycles (16 for W=14).
- Back-to-back: a start in the `done` cycle (IDLE) is accepted. Throughput is one conversion per W+2 cycles.
- `busy` and `done` are never high in the same cycle.
- Reset mid-conversion:
  - The conversion is aborted and no `done` is produced.
  - All outputs return to their reset values on the next edge.
- Reset has priority over start in the same cycle.

## Test plan

- Reset, then start with value=0 → done in cycle 16; chars = {a,a,a,0}; overflow = 0; busy high in exactly cycles 1..15.
- value=2048, then value=7, then value=100, each waiting for done → chars = {2,0,4,8}, then {a,a,a,7}, then {a,1,0,0} (internal zeros kept).
- value=9999 → {9,9,9,9}, overflow = 0. value=10000 → {a,a,a,a}, overflow = 1. value=16383 → {a,a,a,a}, overflow = 1.
- Start with value=512. In cycle 5, pulse start with value=64 → the second start is ignored; a single done reports {a,5,1,2}. A start in the done cycle with value=64 → {a,a,6,4} 16 cycles later.
- Convert 1024 (chars = {1,0,2,4}). Start with value=8 and assert rst in cycle 6 → no done; after reset chars = {a,a,a,a}, busy = 0. A new start with value=8 → {a,a,a,8}.
- Randomised: 2000 values over 0..16383, compared against a reference decimal model including blanking and overflow; done latency is always 16.
